// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arbiter_pkg;

   typedef enum logic [1:0] {
      MEM_B = 2'b00,
      MEM_H = 2'b01,
      MEM_W = 2'b10
   } mem_size_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } dmem_state_t;

   typedef enum logic {
      OWN_CORE = 1'b0,
      OWN_DMA  = 1'b1
   } dmem_owner_t;

   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   // Size code 2'b11 has no meaning of its own and is handled as a word
   function automatic mem_size_t decode_size(input logic [1:0] code);
      case (code)
         2'b00:   decode_size = MEM_B;
         2'b01:   decode_size = MEM_H;
         default: decode_size = MEM_W;
      endcase
   endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - core, DMA and memory-side signal bundle of the arbiter
interface dmem_arbiter_if #(
   parameter int ADDR_W = 32
);
   logic              i_core_req;
   logic              i_core_we;
   logic [1:0]        i_core_size;
   logic [ADDR_W-1:0] i_core_addr;
   logic [31:0]       i_core_wdata;
   logic              o_core_ack;
   logic [31:0]       o_core_rdata;
   logic              o_core_misaligned;
   logic              o_core_stall;

   logic              i_dma_req;
   logic              i_dma_we;
   logic [ADDR_W-1:0] i_dma_addr;
   logic [31:0]       i_dma_wdata;
   logic              o_dma_ack;
   logic [31:0]       o_dma_rdata;

   logic [ADDR_W-1:0] o_mem_addr;
   logic [31:0]       o_mem_wdata;
   logic [3:0]        o_mem_be;
   logic              o_mem_rd_en;
   logic              o_mem_wr_en;
   logic [31:0]       i_mem_rdata;

   // Arbiter side
   modport slave (
      input  i_core_req, i_core_we, i_core_size, i_core_addr, i_core_wdata,
      output o_core_ack, o_core_rdata, o_core_misaligned, o_core_stall,
      input  i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata,
      output o_dma_ack, o_dma_rdata,
      output o_mem_addr, o_mem_wdata, o_mem_be, o_mem_rd_en, o_mem_wr_en,
      input  i_mem_rdata
   );

   // Requester and memory side
   modport master (
      output i_core_req, i_core_we, i_core_size, i_core_addr, i_core_wdata,
      input  o_core_ack, o_core_rdata, o_core_misaligned, o_core_stall,
      output i_dma_req, i_dma_we, i_dma_addr, i_dma_wdata,
      input  o_dma_ack, o_dma_rdata,
      input  o_mem_addr, o_mem_wdata, o_mem_be, o_mem_rd_en, o_mem_wr_en,
      output i_mem_rdata
   );
endinterface

// File: rtl/dmem_arbiter_lane_align.sv
// rtl/dmem_arbiter_lane_align.sv - byte-lane steering and misalignment check for one access
module dmem_lane_align
   import dmem_arbiter_pkg::*;
(
   input  mem_size_t   size,
   input  logic [1:0]  off,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata,
   output logic        misaligned
);

   logic [31:0] shifted;

   assign shifted = mem_rdata >> {off, 3'b000};

   // Lane enables, replicated store data and right-aligned load data per size
   always_comb begin
      be         = BE_W;
      wdata_rep  = wdata;
      rdata      = shifted;
      misaligned = 1'b0;
      case (size)
         MEM_B: begin
            be        = BE_B << off;
            wdata_rep = {4{wdata[7:0]}};
            rdata     = {24'd0, shifted[7:0]};
         end
         MEM_H: begin
            be         = BE_H << off;
            wdata_rep  = {2{wdata[15:0]}};
            rdata      = {16'd0, shifted[15:0]};
            misaligned = off[0];
         end
         default: begin
            misaligned = (off != 2'b00);
         end
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin sequencer sharing the data memory between core and DMA
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int WAIT_CYCLES = 1,
   parameter int ADDR_W      = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   dmem_arbiter_if.slave bus
);

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES);

   dmem_state_t       state, state_nxt;
   dmem_owner_t       owner, owner_nxt;
   dmem_owner_t       last_grant, last_grant_nxt;
   mem_size_t         lat_size, lat_size_nxt;
   logic [1:0]        lat_off, lat_off_nxt;
   logic              lat_we, lat_we_nxt;
   logic [3:0]        cnt, cnt_nxt;

   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [31:0]       mem_wdata_nxt, core_rdata_nxt, dma_rdata_nxt;
   logic [3:0]        mem_be_nxt;
   logic              rd_en_nxt, wr_en_nxt, core_ack_nxt, dma_ack_nxt, mis_nxt;

   logic              any_req, sel_core;
   mem_size_t         a_size;
   logic [1:0]        a_off;
   logic [31:0]       a_wdata, a_wrep, a_rdata;
   logic [3:0]        a_be;
   logic              a_mis;

   // On a tie the port that did not win last time is chosen
   assign any_req  = bus.i_core_req | bus.i_dma_req;
   assign sel_core = bus.i_core_req & (~bus.i_dma_req | (last_grant == OWN_DMA));

   assign bus.o_core_stall = bus.i_core_req & ~bus.o_core_ack;

   // Aligner sees the live winning request while idle, the latched access afterwards
   always_comb begin
      if (state == IDLE) begin
         a_size  = sel_core ? decode_size(bus.i_core_size) : MEM_W;
         a_off   = sel_core ? bus.i_core_addr[1:0] : 2'b00;
         a_wdata = sel_core ? bus.i_core_wdata : bus.i_dma_wdata;
      end else begin
         a_size  = lat_size;
         a_off   = lat_off;
         a_wdata = bus.o_mem_wdata;
      end
   end

   dmem_lane_align u_align (
      .size       (a_size),
      .off        (a_off),
      .wdata      (a_wdata),
      .mem_rdata  (bus.i_mem_rdata),
      .be         (a_be),
      .wdata_rep  (a_wrep),
      .rdata      (a_rdata),
      .misaligned (a_mis)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // FSM next state: a rejected core access skips ACCESS and goes straight to DONE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (any_req) state_nxt = (sel_core && a_mis) ? DONE : ACCESS;
         ACCESS:  if (cnt == 4'd0) state_nxt = DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM outputs: next values of every registered output and of the access context
   always_comb begin
      owner_nxt      = owner;
      last_grant_nxt = last_grant;
      lat_size_nxt   = lat_size;
      lat_off_nxt    = lat_off;
      lat_we_nxt     = lat_we;
      cnt_nxt        = cnt;
      mem_addr_nxt   = bus.o_mem_addr;
      mem_be_nxt     = bus.o_mem_be;
      mem_wdata_nxt  = bus.o_mem_wdata;
      rd_en_nxt      = bus.o_mem_rd_en;
      wr_en_nxt      = bus.o_mem_wr_en;
      core_rdata_nxt = bus.o_core_rdata;
      dma_rdata_nxt  = bus.o_dma_rdata;
      core_ack_nxt   = 1'b0;
      dma_ack_nxt    = 1'b0;
      mis_nxt        = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               if (sel_core && a_mis) begin
                  core_ack_nxt   = 1'b1;
                  mis_nxt        = 1'b1;
                  core_rdata_nxt = '0;
               end else begin
                  owner_nxt      = sel_core ? OWN_CORE : OWN_DMA;
                  last_grant_nxt = owner_nxt;
                  lat_we_nxt     = sel_core ? bus.i_core_we : bus.i_dma_we;
                  lat_size_nxt   = a_size;
                  lat_off_nxt    = a_off;
                  cnt_nxt        = CNT_INIT;
                  mem_addr_nxt   = sel_core ? {bus.i_core_addr[ADDR_W-1:2], 2'b00}
                                            : {bus.i_dma_addr[ADDR_W-1:2], 2'b00};
                  mem_be_nxt     = a_be;
                  mem_wdata_nxt  = a_wrep;
                  rd_en_nxt      = ~lat_we_nxt;
                  wr_en_nxt      = lat_we_nxt;
               end
            end
         end
         ACCESS: begin
            if (cnt == 4'd0) begin
               rd_en_nxt = 1'b0;
               wr_en_nxt = 1'b0;
               if (owner == OWN_CORE) begin
                  core_ack_nxt   = 1'b1;
                  core_rdata_nxt = a_rdata;
               end else begin
                  dma_ack_nxt    = 1'b1;
                  dma_rdata_nxt  = a_rdata;
               end
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         default: ;
      endcase
   end

   // Access context and registered outputs; reset drops the strobes at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner                 <= OWN_CORE;
         last_grant            <= OWN_DMA;
         lat_size              <= MEM_B;
         lat_off               <= 2'b00;
         lat_we                <= 1'b0;
         cnt                   <= 4'd0;
         bus.o_mem_addr        <= '0;
         bus.o_mem_be          <= 4'd0;
         bus.o_mem_wdata       <= 32'd0;
         bus.o_mem_rd_en       <= 1'b0;
         bus.o_mem_wr_en       <= 1'b0;
         bus.o_core_rdata      <= 32'd0;
         bus.o_dma_rdata       <= 32'd0;
         bus.o_core_ack        <= 1'b0;
         bus.o_dma_ack         <= 1'b0;
         bus.o_core_misaligned <= 1'b0;
      end else begin
         owner                 <= owner_nxt;
         last_grant            <= last_grant_nxt;
         lat_size              <= lat_size_nxt;
         lat_off               <= lat_off_nxt;
         lat_we                <= lat_we_nxt;
         cnt                   <= cnt_nxt;
         bus.o_mem_addr        <= mem_addr_nxt;
         bus.o_mem_be          <= mem_be_nxt;
         bus.o_mem_wdata       <= mem_wdata_nxt;
         bus.o_mem_rd_en       <= rd_en_nxt;
         bus.o_mem_wr_en       <= wr_en_nxt;
         bus.o_core_rdata      <= core_rdata_nxt;
         bus.o_dma_rdata       <= dma_rdata_nxt;
         bus.o_core_ack        <= core_ack_nxt;
         bus.o_dma_ack         <= dma_ack_nxt;
         bus.o_core_misaligned <= mis_nxt;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   localparam int W = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;

   initial forever #5 clk = ~clk;

   dmem_arbiter_if #(.ADDR_W(32)) bus ();

   dmem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, required 0x%08h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %b, required %b at cycle %0d", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] init_word(input int i);
      logic [7:0] b;
      b = 8'(i);
      if (i == 'h40) return 32'hDEADBEEF;
      return {b, ~b, b ^ 8'h5A, 8'hC3};
   endfunction

   // memory attached to the DUT
   logic [31:0] dmem [0:255];
   assign bus.i_mem_rdata = dmem[bus.o_mem_addr[9:2]];

   initial begin
      for (int i = 0; i < 256; i++) dmem[i] = init_word(i);
      forever begin
         @(posedge clk);
         if (bus.o_mem_wr_en)
            for (int i = 0; i < 4; i++)
               if (bus.o_mem_be[i])
                  dmem[bus.o_mem_addr[9:2]][8*i +: 8] <= bus.o_mem_wdata[8*i +: 8];
      end
   end

   // transaction-level model: one record per granted or rejected access
   int          free_at = 0;
   int          r_t = -100;
   bit          r_mis, r_own, r_we;
   logic [31:0] r_addr, r_wdata, r_rdata;
   logic [3:0]  r_be;
   bit          m_last = 1'b1;
   logic [31:0] ref_mem [0:255];

   initial begin : model
      int t, off, sz;
      bit take_c;
      logic [31:0] a, wd, mask;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      forever begin
         @(posedge clk);
         t = cyc;
         if (!rst_n) begin
            r_t = -100;
            free_at = 0;
            m_last = 1'b1;
         end else if (t >= free_at && (bus.i_core_req || bus.i_dma_req)) begin
            take_c = bus.i_core_req && (!bus.i_dma_req || m_last);
            if (take_c) begin
               a = bus.i_core_addr; wd = bus.i_core_wdata;
               sz = int'(bus.i_core_size); r_we = bus.i_core_we;
            end else begin
               a = bus.i_dma_addr; wd = bus.i_dma_wdata; sz = 2; r_we = bus.i_dma_we;
               a[1:0] = 2'b00;
            end
            off = int'(a[1:0]);
            r_t = t;
            r_own = !take_c;
            r_addr = {a[31:2], 2'b00};
            case (sz)
               0: begin r_be = 4'(1 << off); r_wdata = (wd & 32'hFF) * 32'h01010101;
                        mask = 32'hFF; r_mis = 1'b0; end
               1: begin r_be = 4'(3 << off); r_wdata = (wd & 32'hFFFF) * 32'h00010001;
                        mask = 32'hFFFF; r_mis = (off % 2) == 1; end
               default: begin r_be = 4'hF; r_wdata = wd; mask = 32'hFFFFFFFF; r_mis = off != 0; end
            endcase
            r_rdata = r_mis ? 32'd0 : (ref_mem[a[9:2]] >> (8 * off)) & mask;
            if (r_mis) begin
               free_at = t + 2;
            end else begin
               free_at = t + 3 + W;
               m_last = r_own;
               if (r_we)
                  for (int i = 0; i < 4; i++)
                     if (r_be[i]) ref_mem[a[9:2]][8*i +: 8] = r_wdata[8*i +: 8];
            end
         end
         cyc = cyc + 1;
      end
   end

   // every-cycle comparison of all outputs against the model record
   initial begin : compare
      int c;
      bit in_s, ack_now;
      forever begin
         @(negedge clk);
         c = cyc;
         if (!rst_n) begin
            chk("rst_mem_addr", bus.o_mem_addr, 32'd0);
            chk("rst_ctrl", {23'd0, bus.o_mem_be, bus.o_core_ack, bus.o_dma_ack,
                 bus.o_core_misaligned, bus.o_mem_rd_en, bus.o_mem_wr_en}, 32'd0);
            chk("rst_wdata", bus.o_mem_wdata, 32'd0);
            chk("rst_rdata", bus.o_core_rdata | bus.o_dma_rdata, 32'd0);
         end else begin
            in_s = !r_mis && c >= r_t + 1 && c <= r_t + 1 + W;
            ack_now = c == (r_mis ? r_t + 1 : r_t + 2 + W);
            chk1("rd_en", bus.o_mem_rd_en, in_s && !r_we);
            chk1("wr_en", bus.o_mem_wr_en, in_s && r_we);
            chk1("core_ack", bus.o_core_ack, ack_now && !r_own);
            chk1("dma_ack", bus.o_dma_ack, ack_now && r_own);
            chk1("misaligned", bus.o_core_misaligned, ack_now && r_mis);
            chk1("stall", bus.o_core_stall, bus.i_core_req && !(ack_now && !r_own));
            if (in_s) begin
               chk("mem_addr", bus.o_mem_addr, r_addr);
               chk("mem_be", {28'd0, bus.o_mem_be}, {28'd0, r_be});
               if (r_we) chk("mem_wdata", bus.o_mem_wdata, r_wdata);
            end
            if (ack_now && !r_own && (r_mis || !r_we)) chk("core_rdata", bus.o_core_rdata, r_rdata);
            if (ack_now && r_own && !r_we) chk("dma_rdata", bus.o_dma_rdata, r_rdata);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic core_drive(input logic req, input logic we, input logic [1:0] sz,
                             input logic [31:0] a, input logic [31:0] wd);
      bus.i_core_req = req; bus.i_core_we = we; bus.i_core_size = sz;
      bus.i_core_addr = a; bus.i_core_wdata = wd;
   endtask

   task automatic dma_drive(input logic req, input logic we, input logic [31:0] a, input logic [31:0] wd);
      bus.i_dma_req = req; bus.i_dma_we = we; bus.i_dma_addr = a; bus.i_dma_wdata = wd;
   endtask

   task automatic wait_ack(input bit dma, input string name, output int at);
      int n;
      n = 0;
      at = -1;
      while (n < 40 && at < 0) begin
         @(negedge clk);
         if (dma ? bus.o_dma_ack : bus.o_core_ack) at = cyc;
         n++;
      end
      vectors++;
      if (at < 0) begin
         miscompares++;
         $display("FAIL %s: no ack within 40 cycles, required one", name);
      end
   endtask

   initial begin : stimulus
      int t0, tq, at, at2, k, n;
      int who [4];
      int when_c [4];
      core_drive(1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
      dma_drive(1'b1, 1'b0, 32'h104, 32'h0);
      repeat (3) step();
      chk("reset_be", {28'd0, bus.o_mem_be}, 32'd0);
      rst_n = 1'b1;
      t0 = cyc;

      // both held from reset: C, D, C, D, spaced 2+W plus one idle cycle
      k = 0; n = 0;
      while (k < 4 && n < 80) begin
         @(negedge clk);
         n++;
         if (bus.o_core_ack) begin who[k] = 0; when_c[k] = cyc; k++; end
         else if (bus.o_dma_ack) begin who[k] = 1; when_c[k] = cyc; k++; end
      end
      chk("rr_acks", k, 4);
      for (int i = 0; i < k; i++) begin
         chk("rr_owner", who[i], i % 2);
         chk("rr_time", when_c[i] - t0, 3 + 4 * i);
      end
      step();
      core_drive(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
      dma_drive(1'b0, 1'b0, 32'h0, 32'h0);

      // core LW 0x100
      step();
      core_drive(1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
      tq = cyc;
      wait_ack(0, "lw_ack", at);
      chk("lw_latency", at - tq, 2 + W);
      chk("lw_rdata", bus.o_core_rdata, 32'hDEADBEEF);
      step();
      core_drive(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);

      // core SB 0x203 then byte load of the same address
      step();
      core_drive(1'b1, 1'b1, 2'b00, 32'h203, 32'h000000A5);
      @(negedge clk);
      @(negedge clk);
      chk("sb_addr", bus.o_mem_addr, 32'h200);
      chk("sb_be", {28'd0, bus.o_mem_be}, 32'h8);
      chk("sb_wdata", bus.o_mem_wdata, 32'hA5A5A5A5);
      chk1("sb_wr_en", bus.o_mem_wr_en, 1'b1);
      wait_ack(0, "sb_ack", at);
      step();
      core_drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      step();
      core_drive(1'b1, 1'b0, 2'b00, 32'h203, 32'h0);
      wait_ack(0, "lb_ack", at);
      chk("lb_rdata", bus.o_core_rdata, 32'h000000A5);
      step();
      core_drive(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);

      // DMA read sets last_grant to D; a misaligned LH must not change it
      step();
      dma_drive(1'b1, 1'b0, 32'h104, 32'h0);
      wait_ack(1, "dma_rd_ack", at);
      step();
      dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
      step();
      core_drive(1'b1, 1'b0, 2'b01, 32'h101, 32'h0);
      tq = cyc;
      wait_ack(0, "lh_mis_ack", at);
      chk("lh_mis_latency", at - tq, 1);
      chk1("lh_mis_flag", bus.o_core_misaligned, 1'b1);
      chk("lh_mis_rdata", bus.o_core_rdata, 32'd0);
      step();
      core_drive(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
      step();
      core_drive(1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
      dma_drive(1'b1, 1'b1, 32'h108, 32'h12345678);
      tq = cyc;
      wait_ack(0, "tie_core_ack", at);
      chk("tie_core_first", at - tq, 2 + W);
      step();
      core_drive(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
      wait_ack(1, "tie_dma_ack", at2);
      chk("tie_dma_after", at2 - at, 3 + W);
      step();
      dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
      step();
      core_drive(1'b1, 1'b0, 2'b10, 32'h108, 32'h0);
      wait_ack(0, "lw_dma_data_ack", at);
      chk("lw_dma_data", bus.o_core_rdata, 32'h12345678);
      step();
      core_drive(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);

      // DMA read in progress, core arrives mid-access
      step();
      dma_drive(1'b1, 1'b0, 32'h103, 32'h0);
      tq = cyc;
      step();
      core_drive(1'b1, 1'b0, 2'b10, 32'h108, 32'h0);
      wait_ack(1, "busy_dma_ack", at);
      chk("busy_dma_latency", at - tq, 2 + W);
      chk("busy_dma_rdata", bus.o_dma_rdata, 32'hDEADBEEF);
      step();
      dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
      wait_ack(0, "busy_core_ack", at2);
      chk("busy_core_after", at2 - at, 3 + W);
      step();
      core_drive(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);

      // reset in ACCESS: strobes drop at once, then a held core wins the tie
      step();
      core_drive(1'b1, 1'b0, 2'b10, 32'h100, 32'h0);
      step();
      chk1("pre_rst_rd_en", bus.o_mem_rd_en, 1'b1);
      rst_n = 1'b0;
      dma_drive(1'b1, 1'b0, 32'h104, 32'h0);
      #1;
      chk1("async_rst_rd_en", bus.o_mem_rd_en, 1'b0);
      chk("async_rst_addr", bus.o_mem_addr, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      tq = cyc;
      wait_ack(0, "post_rst_core_ack", at);
      chk("post_rst_core_first", at - tq, 2 + W);
      step();
      core_drive(1'b0, 1'b0, 2'b10, 32'h0, 32'h0);
      wait_ack(1, "post_rst_dma_ack", at);
      step();
      dma_drive(1'b0, 1'b0, 32'h0, 32'h0);
      repeat (4) step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Sequences all accesses to the single-port data memory and shares it between the core MEM stage (port C) and a DMA/debug requester (port D). Per access it performs round-robin arbitration, wait-state counting, byte-lane alignment and misalignment detection. It sits between memory_access and the data memory, and turns multi-cycle memory accesses into a core stall.

Parameters:
WAIT_CYCLES, 1, extra memory cycles per access (0..15); memory read data is valid on the last ACCESS cycle.
ADDR_W, 32, address width.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
i_core_req  input  1  core access request, held until o_core_ack
i_core_we  input  1  1 = store, 0 = load
i_core_size  input  2  00 = B, 01 = H, 10 = W (11 treated as W)
i_core_addr  input  ADDR_W  byte address
i_core_wdata  input  32  store data, right-aligned
o_core_ack  output  1  one-cycle completion pulse
o_core_rdata  output  32  load data shifted to bits [7:0]/[15:0]/[31:0], upper bits zero
o_core_misaligned  output  1  pulses with o_core_ack when the access was rejected
o_core_stall  output  1  i_core_req && !o_core_ack (combinational)
i_dma_req  input  1  DMA word request, held until o_dma_ack
i_dma_we  input  1  1 = write
i_dma_addr  input  ADDR_W  word address; bits [1:0] are ignored
i_dma_wdata  input  32  write data
o_dma_ack  output  1  one-cycle completion pulse
o_dma_rdata  output  32  read word
o_mem_addr  output  ADDR_W  word-aligned address ({addr[ADDR_W-1:2], 2'b00})
o_mem_wdata  output  32  lane-replicated write data
o_mem_be  output  4  byte enables
o_mem_rd_en  output  1  read strobe
o_mem_wr_en  output  1  write strobe
i_mem_rdata  input  32  memory read word

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low. All outputs except o_core_stall are registered.
- Reset values: every output is 0 and the FSM is in IDLE. last_grant resets to D, so C wins the first tie.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If exactly one request is present, grant it. If both are present, grant the port that is not last_grant, then update last_grant.
  - On grant, latch owner, we, aligned address, be and wdata; set cnt = WAIT_CYCLES; go to ACCESS. o_mem_rd_en = !we and o_mem_wr_en = we are asserted from the next cycle.
- Misaligned core request:
  - Conditions: H with addr[0]=1, or W with addr[1:0]!=0.
  - The request is not granted. The next cycle pulses o_core_ack=1 with o_core_misaligned=1 and o_core_rdata=0.
  - No memory strobe is issued, and last_grant is unchanged. It then returns to IDLE.
- ACCESS:
  - Memory outputs stay stable for the whole state.
  - Decrement cnt each cycle.
  - When cnt==0: capture i_mem_rdata >> (8*addr[1:0]), masked to the access size (DMA: full word); drop both strobes; go to DONE.
- DONE: pulse the owner's ack for one cycle with rdata valid, then return to IDLE. A new grant is possible on the cycle after DONE, never in the same cycle.
- Latency: request in IDLE at cycle T gives ack at T+2+WAIT_CYCLES. Minimum is 2 cycles.
- Byte enables and write data:
  - B: be = 0001 << off, wdata = {4{wdata[7:0]}}.
  - H: be = 0011 << off, wdata = {2{wdata[15:0]}}.
  - W: be = 1111.
  - Loads use the same be.
- Requester drops req mid-access: the access completes and the ack still pulses; the requester ignores it.
- Reset asserted mid-access: strobes drop immediately (asynchronous) and the access is abandoned; no ack is issued.
- Sign extension is not done here; the MEM stage extends from the low bits.

Decomposition:
- riscv_definitions package gets:
  - mem_size_t (MEM_B, MEM_H, MEM_W)
  - dmem_state_t (IDLE, ACCESS, DONE)
  - dmem_owner_t (OWN_CORE, OWN_DMA)
  - constants BE_B = 4'b0001, BE_H = 4'b0011, BE_W = 4'b1111
- One combinational sub-module, dmem_lane_align. It takes size and offset and produces be, replicated wdata, the shifted/masked rdata and the misaligned flag.
- The arbiter instantiates dmem_lane_align once, on the muxed request.

Test Plan:
- WAIT_CYCLES=1, core LW at 0x100, mem word 0xDEADBEEF → rd_en for 2 cycles, be=1111, o_core_ack at T+3, rdata 0xDEADBEEF, stall high T..T+2.
- Core SB addr 0x203, wdata 0x000000A5 → o_mem_addr 0x200, be=1000, o_mem_wdata 0xA5A5A5A5, wr_en 2 cycles; LBU-size load of the same address returns 0x000000A5.
- Core LH addr 0x101 → no strobe, o_core_ack & o_core_misaligned pulse at T+1, rdata 0, last_grant unchanged.
- Both requests held continuously from reset → grants alternate C, D, C, D; each ack spaced 2+WAIT_CYCLES cycles plus one IDLE cycle.
- DMA read in progress, core requests mid-ACCESS → core stalls until DMA DONE, then is granted; o_core_ack at DMA ack + 1 + 2 + WAIT_CYCLES.
- rst_n pulsed low during ACCESS → all outputs 0 asynchronously, no ack; after release, a held core request is granted first.
